// File: rtl/wcp_pkg.sv
// Shared encodings, FSM states and default tuning constants for the
// wavelet coefficient packer.
package wcp_pkg;

  localparam logic [1:0] KIND_L   = 2'd0;
  localparam logic [1:0] KIND_H   = 2'd1;
  localparam logic [1:0] KIND_RUN = 2'd2;

  localparam int DEFAULT_THRESH  = 4;
  localparam int DEFAULT_MAX_RUN = 255;

  typedef enum logic [1:0] {
    S_IDLE,
    S_L,
    S_RUN,
    S_H
  } state_t;

endpackage

// File: rtl/coef_fifo.sv
// Small synchronous FIFO holding {l, h, last} coefficient pairs ahead of the
// packing FSM. Read data is presented combinationally from the head entry.
module coef_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is left unreset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wavelet_coef_packer.sv
// Packs (L, H) wavelet pairs into a tagged byte stream: L literals, H literals
// for H outside the dead zone, and RUN tokens counting dead-zone H values.
module wavelet_coef_packer
  import wcp_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int THRESH     = DEFAULT_THRESH,
  parameter int MAX_RUN    = DEFAULT_MAX_RUN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_l,
  input  logic [DATA_W-1:0] in_h,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_byte,
  output logic [1:0]        out_kind,
  output logic              out_last
);

  localparam int FW = 2 * DATA_W + 1;
  localparam logic signed [DATA_W-1:0] TH_POS  = DATA_W'(THRESH);
  localparam logic signed [DATA_W-1:0] TH_NEG  = DATA_W'(-THRESH);
  localparam logic [DATA_W-1:0]        RUN_SAT = DATA_W'(MAX_RUN);

  logic [FW-1:0]     fifo_wr;
  logic [FW-1:0]     fifo_rd;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  logic [DATA_W-1:0] pop_l;
  logic [DATA_W-1:0] pop_h;
  logic              pop_last;
  logic              pop_zero;

  state_t            state;
  logic [DATA_W-1:0] run;
  logic [DATA_W-1:0] run_val;
  logic [DATA_W-1:0] cur_h;
  logic              cur_last;
  logic              has_run;
  logic              has_h;

  logic              beat_done;
  logic              final_beat;
  logic [DATA_W-1:0] run_inc;
  logic              nxt_has_run;
  logic [DATA_W-1:0] nxt_run_val;
  logic [DATA_W-1:0] nxt_run;

  assign fifo_wr  = {in_l, in_h, in_last};
  assign push     = in_valid && !fifo_full;
  assign in_ready = !fifo_full;

  coef_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (fifo_wr),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pop_l    = fifo_rd[FW-1 -: DATA_W];
  assign pop_h    = fifo_rd[DATA_W:1];
  assign pop_last = fifo_rd[0];
  assign pop_zero = ($signed(pop_h) >= TH_NEG) && ($signed(pop_h) <= TH_POS);

  assign beat_done  = out_valid && out_ready;
  assign final_beat = (state == S_H) ||
                      (state == S_RUN && !has_h) ||
                      (state == S_L && !has_run && !has_h);
  assign pop = ((state == S_IDLE) || (beat_done && final_beat)) && !fifo_empty;

  // The whole beat plan for a pair is fixed at pop time, so the run counter
  // only ever moves once per pair and later states just replay the plan.
  always_comb begin
    run_inc     = run + 1'b1;
    nxt_has_run = 1'b0;
    nxt_run_val = run;
    nxt_run     = '0;
    if (pop_zero) begin
      nxt_run_val = run_inc;
      if ((run_inc == RUN_SAT) || pop_last) begin
        nxt_has_run = 1'b1;
        nxt_run     = '0;
      end else begin
        nxt_run     = run_inc;
      end
    end else begin
      nxt_has_run = (run != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_byte  <= '0;
      out_kind  <= KIND_L;
      out_last  <= 1'b0;
      run       <= '0;
      run_val   <= '0;
      cur_h     <= '0;
      cur_last  <= 1'b0;
      has_run   <= 1'b0;
      has_h     <= 1'b0;
    end else if (pop) begin
      state     <= S_L;
      out_valid <= 1'b1;
      out_byte  <= pop_l;
      out_kind  <= KIND_L;
      out_last  <= 1'b0;
      run       <= nxt_run;
      run_val   <= nxt_run_val;
      cur_h     <= pop_h;
      cur_last  <= pop_last;
      has_run   <= nxt_has_run;
      has_h     <= !pop_zero;
    end else if (beat_done) begin
      case (state)
        S_L: begin
          if (has_run) begin
            state    <= S_RUN;
            out_byte <= run_val;
            out_kind <= KIND_RUN;
            out_last <= cur_last && !has_h;
          end else if (has_h) begin
            state    <= S_H;
            out_byte <= cur_h;
            out_kind <= KIND_H;
            out_last <= cur_last;
          end else begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        S_RUN: begin
          if (has_h) begin
            state    <= S_H;
            out_byte <= cur_h;
            out_kind <= KIND_H;
            out_last <= cur_last;
          end else begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wavelet_coef_packer.sv
// Directed self-checking bench for wavelet_coef_packer: ordering, dead-zone
// boundaries, run saturation, backpressure, mid-pair reset and FIFO overlap.
module tb_wavelet_coef_packer;
  import wcp_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_l;
  logic [7:0] in_h;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic [1:0] out_kind;
  logic       out_last;

  int total = 0;
  int bad   = 0;

  logic [10:0] got[$];
  logic [10:0] exp[$];
  logic        hold_chk = 1'b0;
  logic        prev_stall = 1'b0;
  logic [10:0] prev_beat = '0;

  wavelet_coef_packer #(
    .DATA_W     (8),
    .THRESH     (4),
    .MAX_RUN    (255),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_l      (in_l),
    .in_h      (in_h),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_kind  (out_kind),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] beat(input logic [1:0] k, input logic [7:0] b, input logic l);
    return {k, b, l};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic [7:0] l, input logic [7:0] h, input logic last);
    int c = 0;
    in_valid = 1'b1;
    in_l     = l;
    in_h     = h;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!in_ready) check_output("push_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int c = 0;
    while (got.size() < n && c < 400) begin
      step();
      c++;
    end
    repeat (3) step();
  endtask

  task automatic check_beats(input string tag);
    check_output({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) check_output($sformatf("%s_%0d", tag, i), {21'd0, got[i]}, {21'd0, exp[i]});
    end
  endtask

  // Handshaken beats are captured half a cycle before the accepting edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back({out_kind, out_byte, out_last});
  end

  always @(negedge clk) begin
    if (hold_chk && prev_stall) begin
      check_output("stall_valid", {31'd0, out_valid}, 32'd1);
      check_output("stall_hold", {21'd0, out_kind, out_byte, out_last}, {21'd0, prev_beat});
    end
    prev_stall = hold_chk && out_valid && !out_ready;
    prev_beat  = {out_kind, out_byte, out_last};
  end

  initial begin
    int runs;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_l      = '0;
    in_h      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] reset state");
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_out_byte", {24'd0, out_byte}, 32'd0);
    check_output("rst_out_kind", {30'd0, out_kind}, 32'd0);
    check_output("rst_out_last", {31'd0, out_last}, 32'd0);
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] basic ordering");
    out_ready = 1'b1;
    got.delete();
    apply_stimulus(8'd145, 8'h02, 1'b0);
    apply_stimulus(8'd56,  8'hFD, 1'b0);
    apply_stimulus(8'd49,  8'h05, 1'b1);
    wait_beats(5);
    exp.delete();
    exp.push_back(beat(KIND_L,   8'd145, 1'b0));
    exp.push_back(beat(KIND_L,   8'd56,  1'b0));
    exp.push_back(beat(KIND_L,   8'd49,  1'b0));
    exp.push_back(beat(KIND_RUN, 8'd2,   1'b0));
    exp.push_back(beat(KIND_H,   8'h05,  1'b1));
    check_beats("basic");

    $display("[TB] dead-zone boundaries");
    got.delete();
    apply_stimulus(8'd90, 8'h04, 1'b1);
    apply_stimulus(8'd90, 8'hFB, 1'b0);
    wait_beats(4);
    exp.delete();
    exp.push_back(beat(KIND_L,   8'd90,  1'b0));
    exp.push_back(beat(KIND_RUN, 8'd1,   1'b1));
    exp.push_back(beat(KIND_L,   8'd90,  1'b0));
    exp.push_back(beat(KIND_H,   8'hFB,  1'b0));
    check_beats("bound");

    $display("[TB] run saturation");
    got.delete();
    for (int i = 0; i < 256; i++) apply_stimulus(i[7:0], 8'h00, 1'b0);
    wait_beats(257);
    check_output("sat_count", got.size(), 32'd257);
    if (got.size() >= 257) begin
      check_output("sat_l254", {21'd0, got[254]}, {21'd0, beat(KIND_L, 8'd254, 1'b0)});
      check_output("sat_run", {21'd0, got[255]}, {21'd0, beat(KIND_RUN, 8'd255, 1'b0)});
      check_output("sat_l255", {21'd0, got[256]}, {21'd0, beat(KIND_L, 8'd255, 1'b0)});
    end
    runs = 0;
    foreach (got[i]) if (got[i][10:9] == KIND_RUN) runs++;
    check_output("sat_run_tokens", runs, 32'd1);
    got.delete();
    apply_stimulus(8'd7, 8'h30, 1'b1);
    wait_beats(3);
    exp.delete();
    exp.push_back(beat(KIND_L,   8'd7,  1'b0));
    exp.push_back(beat(KIND_RUN, 8'd1,  1'b0));
    exp.push_back(beat(KIND_H,   8'h30, 1'b1));
    check_beats("pending");

    $display("[TB] backpressure burst");
    out_ready = 1'b0;
    got.delete();
    hold_chk = 1'b1;
    apply_stimulus(8'd10, 8'h00, 1'b0);
    apply_stimulus(8'd11, 8'h20, 1'b0);
    apply_stimulus(8'd12, 8'h01, 1'b0);
    apply_stimulus(8'd13, 8'hFF, 1'b0);
    apply_stimulus(8'd14, 8'h80, 1'b0);
    check_output("burst_full", {31'd0, in_ready}, 32'd0);
    check_output("burst_valid", {31'd0, out_valid}, 32'd1);
    step();
    step();
    check_output("burst_hold_byte", {24'd0, out_byte}, 32'd10);
    check_output("burst_hold_kind", {30'd0, out_kind}, 32'd0);
    fork
      apply_stimulus(8'd15, 8'h03, 1'b1);
      begin
        for (int c = 0; c < 100 && got.size() < 11; c++) begin
          out_ready = (c % 2 == 0);
          step();
        end
        out_ready = 1'b1;
      end
    join
    wait_beats(11);
    hold_chk = 1'b0;
    exp.delete();
    exp.push_back(beat(KIND_L,   8'd10,  1'b0));
    exp.push_back(beat(KIND_L,   8'd11,  1'b0));
    exp.push_back(beat(KIND_RUN, 8'd1,   1'b0));
    exp.push_back(beat(KIND_H,   8'h20,  1'b0));
    exp.push_back(beat(KIND_L,   8'd12,  1'b0));
    exp.push_back(beat(KIND_L,   8'd13,  1'b0));
    exp.push_back(beat(KIND_L,   8'd14,  1'b0));
    exp.push_back(beat(KIND_RUN, 8'd2,   1'b0));
    exp.push_back(beat(KIND_H,   8'h80,  1'b0));
    exp.push_back(beat(KIND_L,   8'd15,  1'b0));
    exp.push_back(beat(KIND_RUN, 8'd1,   1'b1));
    check_beats("burst");

    $display("[TB] reset mid-pair");
    out_ready = 1'b1;
    got.delete();
    apply_stimulus(8'd20, 8'h00, 1'b0);
    wait_beats(1);
    out_ready = 1'b0;
    apply_stimulus(8'd21, 8'h40, 1'b0);
    apply_stimulus(8'd22, 8'h00, 1'b0);
    apply_stimulus(8'd23, 8'h00, 1'b0);
    apply_stimulus(8'd24, 8'h00, 1'b1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_output("pre_rst_kind", {30'd0, out_kind}, {30'd0, KIND_RUN});
    check_output("pre_rst_byte", {24'd0, out_byte}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("rst_async_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_async_byte", {24'd0, out_byte}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    got.delete();
    out_ready = 1'b1;
    step();
    check_output("post_rst_ready", {31'd0, in_ready}, 32'd1);
    check_output("post_rst_count", {29'd0, dut.u_fifo.count}, 32'd0);
    step();
    step();
    check_output("post_rst_beats", got.size(), 32'd0);
    apply_stimulus(8'd77, 8'h10, 1'b1);
    check_output("lat_t0_valid", {31'd0, out_valid}, 32'd0);
    step();
    check_output("lat_t1_valid", {31'd0, out_valid}, 32'd1);
    check_output("lat_t1_byte", {24'd0, out_byte}, 32'd77);
    wait_beats(2);
    exp.delete();
    exp.push_back(beat(KIND_L, 8'd77,  1'b0));
    exp.push_back(beat(KIND_H, 8'h10,  1'b1));
    check_beats("after_rst");

    $display("[TB] simultaneous push and pop");
    out_ready = 1'b0;
    got.delete();
    apply_stimulus(8'd30, 8'h00, 1'b0);
    apply_stimulus(8'd31, 8'h50, 1'b0);
    apply_stimulus(8'd32, 8'h60, 1'b0);
    apply_stimulus(8'd33, 8'h70, 1'b0);
    check_output("pre_simul_count", {29'd0, dut.u_fifo.count}, 32'd3);
    in_valid  = 1'b1;
    in_l      = 8'd34;
    in_h      = 8'h02;
    in_last   = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_output("simul_count", {29'd0, dut.u_fifo.count}, 32'd3);
    check_output("simul_ready", {31'd0, in_ready}, 32'd1);
    check_output("simul_head", {24'd0, out_byte}, 32'd31);
    out_ready = 1'b1;
    wait_beats(10);
    exp.delete();
    exp.push_back(beat(KIND_L,   8'd30, 1'b0));
    exp.push_back(beat(KIND_L,   8'd31, 1'b0));
    exp.push_back(beat(KIND_RUN, 8'd1,  1'b0));
    exp.push_back(beat(KIND_H,   8'h50, 1'b0));
    exp.push_back(beat(KIND_L,   8'd32, 1'b0));
    exp.push_back(beat(KIND_H,   8'h60, 1'b0));
    exp.push_back(beat(KIND_L,   8'd33, 1'b0));
    exp.push_back(beat(KIND_H,   8'h70, 1'b0));
    exp.push_back(beat(KIND_L,   8'd34, 1'b0));
    exp.push_back(beat(KIND_RUN, 8'd1,  1'b1));
    check_beats("simul");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
